// File: rtl/vga_avalon_plotter_pkg.sv
// rtl/vga_avalon_plotter_pkg.sv - shared constants, register map and types for the pixel plotter
// Pixel field widths here fix the layout of pixel_t stored in the plot FIFO.
package vga_plot_pkg;

  localparam int DEF_H_RES    = 160;
  localparam int DEF_V_RES    = 120;
  localparam int PIX_X_W      = 8;
  localparam int PIX_Y_W      = 7;
  localparam int PIX_COLOUR_W = 8;

  localparam logic [3:0] ADDR_PLOT   = 4'd0;
  localparam logic [3:0] ADDR_CLEAR  = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_DROPS  = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PIX_COLOUR_W-1:0] colour;
    logic [PIX_Y_W-1:0]      y;
    logic [PIX_X_W-1:0]      x;
  } pixel_t;

endpackage

// File: rtl/vga_avalon_plotter_if.sv
// rtl/vga_avalon_plotter_if.sv - Avalon-MM register port plus vga_adapter-style pixel port
// The master side is the interconnect/bench; the slave side is the plotter.
interface vga_avalon_plotter_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 8
);
  logic [3:0]          address;
  logic                read;
  logic [31:0]         readdata;
  logic                write;
  logic [31:0]         writedata;
  logic                waitrequest;
  logic                pix_plot;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest, pix_plot, pix_x, pix_y, pix_colour
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest, pix_plot, pix_x, pix_y, pix_colour
  );
endinterface

// File: rtl/vga_avalon_plotter_fifo.sv
// rtl/vga_avalon_plotter_fifo.sv - synchronous FIFO of pixel_t with level output
// Push when full and pop when empty are ignored; DEPTH must be a power of two.
module plot_fifo
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  pixel_t                 i_data,
  input  logic                   i_pop,
  output pixel_t                 o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  pixel_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vga_avalon_plotter.sv
// rtl/vga_avalon_plotter.sv - Avalon-MM plot/clear engine feeding a vga_adapter pixel port
// Queued plots drain one per cycle; CLEAR sweeps the whole screen with a latched colour.
module vga_avalon_plotter
  import vga_plot_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int X_W        = PIX_X_W,
  parameter int Y_W        = PIX_Y_W,
  parameter int COLOUR_W   = PIX_COLOUR_W,
  parameter int FIFO_DEPTH = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  vga_avalon_plotter_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [X_W-1:0]      w_x;
  logic [Y_W-1:0]      w_y;
  logic [COLOUR_W-1:0] w_colour;
  logic                w_in_range;
  logic                w_plot_wr;
  logic                w_clear_wr;
  logic                w_plot_stall;
  logic                w_clear_stall;
  logic                w_push;
  logic                w_drop;
  logic                w_clear_go;
  logic                w_pop;
  logic                w_fill_step;
  logic                w_busy;
  logic                w_full;
  logic                w_empty;
  logic [LW-1:0]       w_level;
  pixel_t              w_push_pix;
  pixel_t              w_head;
  logic [31:0]         w_readdata;
  logic [X_W-1:0]      r_fill_x;
  logic [Y_W-1:0]      r_fill_y;
  logic [COLOUR_W-1:0] r_fill_colour;
  logic [31:0]         r_drops;
  logic                r_pix_plot;
  logic [X_W-1:0]      r_pix_x;
  logic [Y_W-1:0]      r_pix_y;
  logic [COLOUR_W-1:0] r_pix_colour;

  assign w_colour   = bus.writedata[COLOUR_W-1:0];
  assign w_x        = bus.writedata[16 +: X_W];
  assign w_y        = bus.writedata[24 +: Y_W];
  assign w_in_range = (32'(w_x) < 32'(H_RES)) && (32'(w_y) < 32'(V_RES));
  assign w_plot_wr  = bus.write && (bus.address == ADDR_PLOT);
  assign w_clear_wr = bus.write && (bus.address == ADDR_CLEAR);
  assign w_busy     = (r_state != ST_IDLE);

  // Off-screen plots are swallowed even when the FIFO is full, so they never stall.
  assign w_plot_stall  = w_plot_wr && w_in_range && w_full;
  assign w_clear_stall = w_clear_wr && (w_busy || !w_empty);
  assign w_push        = w_plot_wr && w_in_range && !w_full;
  assign w_drop        = w_plot_wr && !w_in_range;
  assign w_clear_go    = w_clear_wr && !w_clear_stall;

  assign w_push_pix.colour = w_colour;
  assign w_push_pix.y      = w_y;
  assign w_push_pix.x      = w_x;

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_pix),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // IDLE pops straight away so a lone plot reaches the pixel port two cycles after acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_fill_step = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DRAIN: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ((w_level > LW'(1)) || w_push) ? ST_DRAIN : ST_IDLE;
        end else if (w_clear_go) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        w_fill_step = 1'b1;
        if ((r_fill_x == X_LAST) && (r_fill_y == Y_LAST)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_x      <= '0;
      r_fill_y      <= '0;
      r_fill_colour <= '0;
      r_drops       <= '0;
      r_pix_plot    <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_colour  <= '0;
    end else begin
      r_pix_plot <= w_pop || w_fill_step;
      if (w_clear_go) begin
        r_fill_x      <= '0;
        r_fill_y      <= '0;
        r_fill_colour <= w_colour;
      end else if (w_fill_step) begin
        if (r_fill_x == X_LAST) begin
          r_fill_x <= '0;
          r_fill_y <= r_fill_y + Y_W'(1);
        end else begin
          r_fill_x <= r_fill_x + X_W'(1);
        end
      end
      if (w_pop) begin
        r_pix_x      <= w_head.x;
        r_pix_y      <= w_head.y;
        r_pix_colour <= w_head.colour;
      end else if (w_fill_step) begin
        r_pix_x      <= r_fill_x;
        r_pix_y      <= r_fill_y;
        r_pix_colour <= r_fill_colour;
      end
      if (w_drop && (r_drops != '1)) r_drops <= r_drops + 32'd1;
    end
  end

  always_comb begin
    w_readdata = '0;
    if (bus.read && !bus.write) begin
      case (bus.address)
        ADDR_STATUS: w_readdata = {16'b0, 8'(w_level), 5'b0, w_empty, w_full, w_busy};
        ADDR_DROPS:  w_readdata = r_drops;
        default:     w_readdata = '0;
      endcase
    end
  end

  assign bus.readdata    = w_readdata;
  assign bus.waitrequest = w_plot_stall || w_clear_stall;
  assign bus.pix_plot    = r_pix_plot;
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign bus.pix_colour  = r_pix_colour;
endmodule

// File: tb/tb_vga_avalon_plotter.sv
// tb/tb_vga_avalon_plotter.sv - self-checking bench for vga_avalon_plotter
module tb_vga_avalon_plotter;
  import vga_plot_pkg::*;

  localparam int H          = 160;
  localparam int V          = 120;
  localparam int DEPTH      = 8;
  localparam int FILL_N     = H * V;
  localparam int WAIT_LIMIT = 25000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_avalon_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(8)) bus ();

  vga_avalon_plotter #(
    .H_RES(H), .V_RES(V), .X_W(8), .Y_W(7), .COLOUR_W(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] m_drops  = '0;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  always @(negedge clk)
    if (reset_n && bus.pix_plot) obs_q.push_back({bus.pix_colour, 1'b0, bus.pix_y, bus.pix_x});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix(input logic [7:0] c, input logic [6:0] y, input logic [7:0] x);
    return {c, 1'b0, y, x};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
    logic [7:0] x;
    logic [6:0] y;
    logic       acc;
    stalls = 0;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    while (bus.waitrequest && stalls < WAIT_LIMIT) begin
      stalls++;
      @(negedge clk);
    end
    acc = !bus.waitrequest;
    if (!acc) check("write_timeout", {31'b0, bus.waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    if (acc) begin
      x = d[23:16];
      y = d[30:24];
      if (a == ADDR_PLOT) begin
        if (x < H && y < V) exp_q.push_back(pix(d[7:0], y, x));
        else if (m_drops != 32'hFFFF_FFFF) m_drops++;
      end else if (a == ADDR_CLEAR) begin
        for (int yy = 0; yy < V; yy++)
          for (int xx = 0; xx < H; xx++) exp_q.push_back(pix(d[7:0], 7'(yy), 8'(xx)));
      end
    end
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] data);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    data = bus.readdata;
    @(posedge clk);
    #1;
    bus.read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int          k;
    k = 0;
    do begin
      av_read(ADDR_STATUS, st);
      k++;
    end while (st !== 32'h4 && k < 30000);
    check(tag, st, 32'h4);
    idle(2);
  endtask

  task automatic check_stream(input string tag, input bit prefix_only);
    int n;
    int bad;
    if (prefix_only) check({tag, "_len_le"}, 32'(obs_q.size() <= exp_q.size()), 32'h1);
    else             check({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) bad++;
    check({tag, "_mismatches"}, bad, 32'h0);
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [31:0] rand_plot(input bit in_range);
    logic [7:0]  x;
    logic [6:0]  y;
    logic [31:0] junk;
    junk = $urandom;
    x = in_range ? 8'($urandom_range(0, H - 1)) : 8'($urandom_range(0, 191));
    y = in_range ? 7'($urandom_range(0, V - 1)) : 7'($urandom_range(0, 127));
    return {junk[31], y, x, junk[15:8], junk[7:0]};
  endfunction

  initial begin
    logic [31:0] rd;
    int          s;
    int          s_sum;
    int          plots;
    int          busy_low;
    int          k;
    int          n_at_reset;

    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_plot", bus.pix_plot, 0);
    check("rst_pix_xyc", {bus.pix_colour, 1'b0, bus.pix_y, bus.pix_x}, 0);
    check("rst_waitreq", bus.waitrequest, 0);
    check("rst_readdata", bus.readdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    av_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h4);
    av_read(ADDR_DROPS, rd);  check("rst_drops", rd, 32'h0);

    // Single plot latency
    av_write(ADDR_PLOT, 32'h0510_003C, s);
    check("t1_stall", s, 0);
    @(negedge clk); check("t1_n1_plot", bus.pix_plot, 0);
    @(negedge clk); check("t1_n2_plot", bus.pix_plot, 1);
    check("t1_n2_pixel", {bus.pix_colour, 1'b0, bus.pix_y, bus.pix_x}, pix(8'h3C, 7'h05, 8'h10));
    @(posedge clk); #1;

    // Off-screen plots are dropped without stalling
    av_write(ADDR_PLOT, {1'b0, 7'd0, 8'd160, 8'h00, 8'h11}, s); check("t3_stall_x", s, 0);
    av_write(ADDR_PLOT, {1'b0, 7'd120, 8'd0, 8'h00, 8'h22}, s); check("t3_stall_y", s, 0);
    idle(4);
    av_read(ADDR_DROPS, rd);  check("t3_drops", rd, m_drops);
    av_read(ADDR_STATUS, rd); check("t3_status", rd, 32'h4);
    check_stream("t13_stream", 1'b0);

    // Ignored writes, reserved read, read+write collision
    av_write(ADDR_STATUS, 32'hFFFF_FFFF, s);
    av_write(4'd7, 32'h0101_0101, s);
    av_read(4'd9, rd); check("rsvd_read", rd, 32'h0);
    bus.address = ADDR_DROPS; bus.writedata = 32'h0; bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    check("rw_readdata", bus.readdata, 32'h0);
    check("rw_waitreq", bus.waitrequest, 0);
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    idle(3);
    av_read(ADDR_DROPS, rd);  check("ign_drops", rd, m_drops);
    av_read(ADDR_STATUS, rd); check("ign_status", rd, 32'h4);

    // Full-screen clear
    av_write(ADDR_CLEAR, 32'h0000_00FF, s); check("t4_stall", s, 0);
    bus.address = ADDR_STATUS; bus.read = 1'b1;
    plots = 0; busy_low = 0; k = 0;
    while (plots < FILL_N && k < FILL_N + 100) begin
      @(negedge clk);
      k++;
      if (plots < FILL_N - 1 && !bus.readdata[0]) busy_low++;
      if (bus.pix_plot) plots++;
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
    check("t4_plot_count", plots, FILL_N);
    check("t4_busy_low_cycles", busy_low, 0);
    idle(2);
    @(negedge clk);
    check("t4_plot_after", bus.pix_plot, 0);
    check("t4_hold_pixel", {bus.pix_colour, 1'b0, bus.pix_y, bus.pix_x}, pix(8'hFF, 7'd119, 8'd159));
    @(posedge clk); #1;
    av_read(ADDR_STATUS, rd); check("t4_status", rd, 32'h4);
    check("t4_first", obs_q[0], pix(8'hFF, 7'd0, 8'd0));
    check("t4_last", obs_q[obs_q.size() - 1], pix(8'hFF, 7'd119, 8'd159));
    check_stream("t4_stream", 1'b0);

    // Plots queued during a clear: FIFO fills, ninth stalls, all drain after the sweep
    av_write(ADDR_CLEAR, 32'h0000_0033, s);
    s_sum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      av_write(ADDR_PLOT, rand_plot(1'b1), s);
      s_sum += s;
    end
    check("t2_first8_stalls", s_sum, 0);
    av_write(ADDR_PLOT, rand_plot(1'b1), s);
    check("t2_ninth_stalls", s, FILL_N - 7);
    wait_idle("t2_idle");
    check_stream("t2_stream", 1'b0);

    // Randomised plots and DROPS reads
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7) av_write(ADDR_PLOT, rand_plot(1'b0), s);
      else if (k == 7) begin
        av_read(ADDR_DROPS, rd);
        check("rnd_drops", rd, m_drops);
      end else idle($urandom_range(1, 3));
    end
    wait_idle("rnd_idle");
    av_read(ADDR_DROPS, rd); check("rnd_drops_final", rd, m_drops);
    check_stream("rnd_stream", 1'b0);

    // CLEAR behind pending plots, then reset mid-sweep
    av_write(ADDR_PLOT, rand_plot(1'b1), s);
    av_write(ADDR_PLOT, rand_plot(1'b1), s);
    av_write(ADDR_CLEAR, 32'h0000_005A, s);
    check("t5_clear_stalled", 32'(s > 0), 32'h1);
    idle(500);
    #2;
    reset_n = 1'b0;
    n_at_reset = obs_q.size();
    m_drops = '0;
    #1;
    check("t6_pix_plot", bus.pix_plot, 0);
    bus.address = ADDR_STATUS; bus.read = 1'b1;
    #1;
    check("t6_status", bus.readdata, 32'h4);
    bus.address = ADDR_DROPS;
    #1;
    check("t6_drops", bus.readdata, m_drops);
    bus.read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(50);
    check("t6_no_more_plots", obs_q.size(), n_at_reset);
    check("t6_partial_fill", 32'(obs_q.size() > 3), 32'h1);
    check_stream("t6_prefix", 1'b1);
    av_read(ADDR_STATUS, rd); check("t6_status_after", rd, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
